// File: rtl/temp_poll_seq.sv
// temp_poll_seq: configures NUM_CH I2C temperature sensors, then polls them
// and writes signed 3-digit ASCII fields into the LCD buffer. Fraction: TEMP_FRAC_EN.
module temp_poll_seq #(
    parameter int          NUM_CH      = 2,
    parameter logic [6:0]  BASE_ADDR   = 7'h18,
    parameter logic [7:0]  CONF_PTR    = 8'h01,
    parameter logic [7:0]  TEMP_PTR    = 8'h05,
    parameter logic [15:0] CONF_WORD   = 16'h0000,
    parameter int          CH_STRIDE   = 8,
    parameter int          POLL_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    input  logic              ready,
    input  logic              ack_e,
    input  logic [7:0]        drd,
    output logic              go,
    output logic              rw,
    output logic [5:0]        n_byte,
    output logic [6:0]        dev_add,
    output logic [7:0]        r_pointer,
    output logic [7:0]        dwr,
    output logic              lcd_w,
    output logic [4:0]        lcd_wadd,
    output logic [7:0]        lcd_din,
    output logic [NUM_CH-1:0] err_flags
);

`ifdef TEMP_FRAC_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
    localparam int         LO_LSB   = 0;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
    localparam int         LO_LSB   = 4;
`endif

    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);
    localparam int PCW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        CFG_IDLE,
        RD_IDLE,
        GO,
        B0,
        B1,
        WAIT_DONE,
        H_LOOP,
        T_LOOP,
        WR,
        WAIT_POLL
    } state_t;

    state_t            state_q, state_d;
    logic              cfg_q, cfg_d;
    logic [1:0]        ch_q, ch_d;
    logic [PCW-1:0]    poll_cnt_q, poll_cnt_d;
    logic              err_q, err_d;
    logic [4:0]        hi_q, hi_d;
    logic [7:LO_LSB]   lo_q, lo_d;
    logic              neg_q, neg_d;
    logic [8:0]        mag_q, mag_d;
    logic [1:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [2:0]        idx_q, idx_d;
    logic              go_q, go_d;
    logic              rw_q, rw_d;
    logic [5:0]        n_byte_q, n_byte_d;
    logic [6:0]        dev_add_q, dev_add_d;
    logic [7:0]        r_pointer_q, r_pointer_d;
    logic [7:0]        dwr_q, dwr_d;
    logic              lcd_w_q, lcd_w_d;
    logic [4:0]        lcd_wadd_q, lcd_wadd_d;
    logic [7:0]        lcd_din_q, lcd_din_d;
    logic [NUM_CH-1:0] err_flags_q, err_flags_d;

    logic [7:0] raw;
    logic [4:0] ch_base;
    logic [7:0] chr;
    logic       err_now;

    assign raw     = {hi_q[3:0], lo_q[7:4]};
    assign ch_base = 5'(CH_STRIDE) * {3'b000, ch_q};
    assign err_now = err_q | ack_e;

`ifdef TEMP_FRAC_EN
    logic [7:0] frac_prod;
    assign frac_prod = {4'b0000, lo_q[3:0]} * 8'd10;
`endif

    // Character for the current field position
    always_comb begin
        chr = 8'h20;
        if (err_q) begin
            case (idx_q)
                3'd0:    chr = 8'h45;
                3'd1:    chr = 8'h52;
                3'd2:    chr = 8'h52;
                default: chr = 8'h20;
            endcase
        end else begin
            case (idx_q)
                3'd0:    chr = neg_q ? 8'h2D : 8'h20;
                3'd1:    chr = 8'h30 + {6'd0, hund_q};
                3'd2:    chr = 8'h30 + {4'd0, tens_q};
                3'd3:    chr = 8'h30 + {4'd0, mag_q[3:0]};
`ifdef TEMP_FRAC_EN
                3'd4:    chr = 8'h2E;
                3'd5:    chr = 8'h30 + (frac_prod >> 4);
`endif
                default: chr = 8'h20;
            endcase
        end
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        ch_d        = ch_q;
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        idx_d       = idx_q;
        go_d        = 1'b0;
        rw_d        = rw_q;
        n_byte_d    = n_byte_q;
        dev_add_d   = dev_add_q;
        r_pointer_d = r_pointer_q;
        dwr_d       = dwr_q;
        lcd_w_d     = 1'b0;
        lcd_wadd_d  = lcd_wadd_q;
        lcd_din_d   = lcd_din_q;
        err_flags_d = err_flags_q;

        case (state_q)
            CFG_IDLE, RD_IDLE: begin
                if (done) begin
                    cfg_d       = (state_q == CFG_IDLE);
                    rw_d        = (state_q == RD_IDLE);
                    n_byte_d    = 6'd2;
                    dev_add_d   = BASE_ADDR + {5'd0, ch_q};
                    r_pointer_d = (state_q == CFG_IDLE) ? CONF_PTR : TEMP_PTR;
                    err_d       = 1'b0;
                    go_d        = 1'b1;
                    state_d     = GO;
                end
            end
            GO: begin
                err_d   = err_now;
                state_d = B0;
            end
            B0: begin
                err_d = err_now;
                if (ready) begin
                    if (cfg_q) dwr_d = CONF_WORD[15:8];
                    else       hi_d  = drd[4:0];
                    state_d = B1;
                end
            end
            B1: begin
                err_d = err_now;
                if (ready) begin
                    if (cfg_q) dwr_d = CONF_WORD[7:0];
                    else       lo_d  = drd[7:LO_LSB];
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                err_d = err_now;
                if (done) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_q == 2'(k)) err_flags_d[k] = err_now;
                    end
                    if (cfg_q) begin
                        if (ch_q == LAST_CH) begin
                            ch_d    = 2'd0;
                            state_d = RD_IDLE;
                        end else begin
                            ch_d    = ch_q + 2'd1;
                            state_d = CFG_IDLE;
                        end
                    end else if (err_now) begin
                        idx_d   = 3'd0;
                        state_d = WR;
                    end else begin
                        neg_d   = hi_q[4];
                        mag_d   = hi_q[4] ? (9'd256 - {1'b0, raw})
                                          : {1'b0, raw};
                        hund_d  = 2'd0;
                        tens_d  = 4'd0;
                        state_d = H_LOOP;
                    end
                end
            end
            H_LOOP: begin
                if (mag_q > 9'd99) begin
                    hund_d = hund_q + 2'd1;
                    mag_d  = mag_q - 9'd100;
                end else begin
                    state_d = T_LOOP;
                end
            end
            T_LOOP: begin
                if (mag_q > 9'd9) begin
                    tens_d = tens_q + 4'd1;
                    mag_d  = mag_q - 9'd10;
                end else begin
                    idx_d   = 3'd0;
                    state_d = WR;
                end
            end
            WR: begin
                lcd_w_d    = 1'b1;
                lcd_wadd_d = ch_base + {2'b00, idx_q};
                lcd_din_d  = chr;
                if (idx_q == LAST_IDX) begin
                    if (ch_q == LAST_CH) begin
                        ch_d       = 2'd0;
                        poll_cnt_d = '0;
                        state_d    = WAIT_POLL;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                        state_d = RD_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            WAIT_POLL: begin
                if (poll_cnt_q == PCW'(POLL_CYCLES)) begin
                    poll_cnt_d = '0;
                    state_d    = RD_IDLE;
                end else begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CFG_IDLE;
            cfg_q       <= 1'b1;
            ch_q        <= 2'd0;
            poll_cnt_q  <= '0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            idx_q       <= '0;
            go_q        <= 1'b0;
            rw_q        <= 1'b0;
            n_byte_q    <= '0;
            dev_add_q   <= '0;
            r_pointer_q <= '0;
            dwr_q       <= '0;
            lcd_w_q     <= 1'b0;
            lcd_wadd_q  <= '0;
            lcd_din_q   <= '0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            ch_q        <= ch_d;
            poll_cnt_q  <= poll_cnt_d;
            err_q       <= err_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            idx_q       <= idx_d;
            go_q        <= go_d;
            rw_q        <= rw_d;
            n_byte_q    <= n_byte_d;
            dev_add_q   <= dev_add_d;
            r_pointer_q <= r_pointer_d;
            dwr_q       <= dwr_d;
            lcd_w_q     <= lcd_w_d;
            lcd_wadd_q  <= lcd_wadd_d;
            lcd_din_q   <= lcd_din_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign go        = go_q;
    assign rw        = rw_q;
    assign n_byte    = n_byte_q;
    assign dev_add   = dev_add_q;
    assign r_pointer = r_pointer_q;
    assign dwr       = dwr_q;
    assign lcd_w     = lcd_w_q;
    assign lcd_wadd  = lcd_wadd_q;
    assign lcd_din   = lcd_din_q;
    assign err_flags = err_flags_q;

endmodule

// File: tb/tb_temp_poll_seq.sv
// tb_temp_poll_seq: I2C master model driving temp_poll_seq, LCD scoreboard.
// Honours TEMP_FRAC_EN for the field width.
module tb_temp_poll_seq;

`ifdef TEMP_FRAC_EN
    localparam int FW = 6;
`else
    localparam int FW = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic       ready;
    logic       ack_e;
    logic [7:0] drd;
    logic       go;
    logic       rw;
    logic [5:0] n_byte;
    logic [6:0] dev_add;
    logic [7:0] r_pointer;
    logic [7:0] dwr;
    logic       lcd_w;
    logic [4:0] lcd_wadd;
    logic [7:0] lcd_din;
    logic [1:0] err_flags;

    always #5 clk = ~clk;

    temp_poll_seq #(
        .NUM_CH(2), .BASE_ADDR(7'h18), .CONF_PTR(8'h01),
        .TEMP_PTR(8'h05), .CONF_WORD(16'h0000),
        .CH_STRIDE(8), .POLL_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .ready(ready),
        .ack_e(ack_e), .drd(drd), .go(go), .rw(rw), .n_byte(n_byte),
        .dev_add(dev_add), .r_pointer(r_pointer), .dwr(dwr),
        .lcd_w(lcd_w), .lcd_wadd(lcd_wadd), .lcd_din(lcd_din),
        .err_flags(err_flags)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        ack;
        logic [47:0] txt;
    } vec_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] chr;
        logic       first;
        logic       err;
        logic       ch;
    } lexp_t;

    lexp_t lq[$];
    int n_chk = 0;
    int n_fail = 0;
    int go_cnt = 0;
    int cfg_done = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (go === 1'b1) go_cnt++;

    // LCD scoreboard: pop one expected character per write strobe
    always @(negedge clk) begin
        if (rst_n === 1'b1 && lcd_w === 1'b1) begin
            chk("lcd_after_cfg", 64'(cfg_done >= 2), 64'd1);
            if (lq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL lcd_unexpected actual=%0h@%0h required=none",
                         lcd_din, lcd_wadd);
            end else begin
                lexp_t e;
                e = lq.pop_front();
                chk("lcd_addr", 64'(lcd_wadd), 64'(e.addr));
                chk("lcd_char", 64'(lcd_din), 64'(e.chr));
                if (e.first) chk("err_flag", 64'(err_flags[e.ch]), 64'(e.err));
            end
        end
    end

    task automatic push_field(input logic ch, input vec_t v);
        for (int i = 0; i < FW; i++) begin
            lexp_t e;
            e.addr  = 5'(ch ? 8 : 0) + 5'(i);
            e.chr   = v.txt[47 - 8*i -: 8];
            e.first = (i == 0);
            e.err   = v.ack;
            e.ch    = ch;
            lq.push_back(e);
        end
    endtask

    // Master model: one transaction, optional stop while DUT sits in B1
    task automatic txn(input logic erw, input logic [6:0] eaddr,
                       input logic [7:0] eptr, input logic [15:0] rdata,
                       input logic ack, input logic stop_b1);
        int t = 0;
        while (go !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (go !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL go_timeout actual=none required=go@%0h", eaddr);
            return;
        end
        chk("rw", 64'(rw), 64'(erw));
        chk("dev_add", 64'(dev_add), 64'(eaddr));
        chk("r_pointer", 64'(r_pointer), 64'(eptr));
        chk("n_byte", 64'(n_byte), 64'd2);
        done = 1'b0;
        @(negedge clk);
        chk("go_width", 64'(go), 64'd0);
        ready = 1'b1;
        drd = rdata[15:8];
        @(negedge clk);
        ready = 1'b0;
        if (!erw) chk("dwr0", 64'(dwr), 64'h00);
        if (ack) ack_e = 1'b1;
        if (stop_b1) return;
        @(negedge clk);
        ack_e = 1'b0;
        ready = 1'b1;
        drd = rdata[7:0];
        @(negedge clk);
        ready = 1'b0;
        if (!erw) chk("dwr1", 64'(dwr), 64'h00);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        int g0;
        int t;
        tbl[0] = '{16'h0190, 1'b0, " 025.0"};
        tbl[1] = '{16'h1E70, 1'b0, "-025.0"};
        tbl[2] = '{16'h1000, 1'b0, "-256.0"};
        tbl[3] = '{16'h0FF0, 1'b0, " 255.0"};
        tbl[4] = '{16'h0000, 1'b0, " 000.0"};
        tbl[5] = '{16'h0190, 1'b1, "ERR   "};
        tbl[6] = '{16'h0198, 1'b0, " 025.5"};
        tbl[7] = '{16'h1E70, 1'b0, "-025.0"};

        rst_n = 1'b0;
        done  = 1'b0;
        ready = 1'b0;
        ack_e = 1'b0;
        drd   = 8'h00;
        #12;
        chk("reset_outs", 64'({go, rw, n_byte, dev_add, r_pointer, dwr,
             lcd_w, lcd_wadd, lcd_din, err_flags}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_go_wo_done", 64'(go_cnt), 64'd0);
        done = 1'b1;

        txn(1'b0, 7'h18, 8'h01, 16'h0, 1'b0, 1'b0);
        cfg_done++;
        txn(1'b0, 7'h19, 8'h01, 16'h0, 1'b0, 1'b0);
        cfg_done++;

        for (int k = 0; k < 8; k++) begin
            push_field(k[0], tbl[k]);
            txn(1'b1, 7'h18 + 7'(k % 2), 8'h05, tbl[k].data,
                tbl[k].ack, 1'b0);
        end

        txn(1'b1, 7'h18, 8'h05, 16'h0190, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({go, rw, n_byte, dev_add, r_pointer, dwr,
             lcd_w, lcd_wadd, lcd_din, err_flags}), 64'd0);
        cfg_done = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        g0 = go_cnt;
        repeat (10) @(negedge clk);
        chk("no_rego_wo_done", 64'(go_cnt - g0), 64'd0);
        done = 1'b1;
        txn(1'b0, 7'h18, 8'h01, 16'h0, 1'b0, 1'b0);
        cfg_done++;
        txn(1'b0, 7'h19, 8'h01, 16'h0, 1'b0, 1'b0);
        cfg_done++;
        push_field(1'b0, tbl[0]);
        txn(1'b1, 7'h18, 8'h05, tbl[0].data, 1'b0, 1'b0);

        t = 0;
        while (lq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("lcd_drain", 64'(lq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
